out_channel_reader: RTL and testbench

Receiving end of the program out channel. Each `out` instruction of a generated test program drives one word onto a valid/ready stream. This block buffers those words, compares each one in order against an expected-value table loaded beforehand, and on program halt reports `finished` and `success`. It replaces the hard-coded default-branch comparison with a reusable, synthesizable checker that sits beside the program core on the FPGA.

---
 rtl/out_channel_pkg.sv | 22 ++
 rtl/out_channel_reader_word_fifo.sv | 52 +++++
 rtl/out_channel_reader.sv | 153 +++++++++++++++
 tb/tb_out_channel_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_channel_pkg.sv
// Shared types and constants for the program out-channel checker.
package out_channel_pkg;

    localparam int WORD_W = 12;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam word_t BAD_NONE = '1;

    // Index width that stays legal for a single-entry table.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_channel_reader_word_fifo.sv
// Small first-word-fall-through FIFO: read data comes straight from the register array.
module word_fifo #(
    parameter int Width = 12,
    parameter int Depth = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count == CW'(Depth));
        empty    = (count == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        pop_data = mem[rd_ptr];
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clock) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/out_channel_reader.sv
// Buffers program out-channel words and checks them in order against a preloaded table.
// Optional build macro OUT_CHANNEL_WRAP_EN: compare index wraps modulo NOut.
module out_channel_reader
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 2,
    parameter int FifoDepth          = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          exp_we,
    input  logic [idx_width(NOut)-1:0]    exp_addr,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    input  logic                          hold,
    input  logic                          halt,
    output logic [MemoryElementWidth-1:0] rx_count,
    output logic [MemoryElementWidth-1:0] bad_index,
    output logic                          finished,
    output logic                          success
);

    localparam int IW = idx_width(NOut);
    localparam int CW = $clog2(FifoDepth) + 1;

    typedef logic [MemoryElementWidth-1:0] mword_t;
    localparam mword_t BadNone = '1;

    state_e          state;
    state_e          state_n;
    mword_t          exp_mem [NOut];

    logic            fifo_push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_n;
    mword_t          fifo_data;

    logic            cmp_vld_p0;
    logic            cmp_hit_p0;
    logic [IW-1:0]   exp_idx_p0;

    logic            error;
    logic            error_n;
    mword_t          rx_n;
    mword_t          bad_n;
    logic            success_n;

    function automatic mword_t sat_inc(input mword_t v);
        return (v == BadNone) ? v : v + 1'b1;
    endfunction

    word_fifo #(
        .Width (MemoryElementWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (start),
        .push      (fifo_push),
        .push_data (out_data),
        .pop       (cmp_vld_p0),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (state == IDLE && exp_we && int'(exp_addr) < NOut) exp_mem[exp_addr] <= exp_data;
    end

    // Stage p0: pop the head word and compare it against its expected entry.
    always_comb begin
        fifo_push  = (state == COLLECT) && out_valid && out_ready && !fifo_full && !start;
        cmp_vld_p0 = (state == COLLECT || state == DRAIN) && !fifo_empty && !hold && !start;
        count_n    = start ? '0 : fifo_count + CW'(fifo_push) - CW'(cmp_vld_p0);
`ifdef OUT_CHANNEL_WRAP_EN
        exp_idx_p0 = IW'(rx_count % mword_t'(NOut));
        cmp_hit_p0 = (fifo_data == exp_mem[exp_idx_p0]);
`else
        exp_idx_p0 = rx_count[IW-1:0];
        cmp_hit_p0 = (rx_count < mword_t'(NOut)) && (fifo_data == exp_mem[exp_idx_p0]);
`endif
    end

    always_comb begin
        rx_n    = rx_count;
        bad_n   = bad_index;
        error_n = error;
        if (start) begin
            rx_n    = '0;
            bad_n   = BadNone;
            error_n = 1'b0;
        end else if (cmp_vld_p0) begin
            rx_n = sat_inc(rx_count);
            if (!cmp_hit_p0) begin
                error_n = 1'b1;
                if (bad_index == BadNone) bad_n = rx_count;
            end
        end
`ifdef OUT_CHANNEL_WRAP_EN
        success_n = !error_n && (rx_n >= mword_t'(NOut));
`else
        success_n = !error_n && (rx_n == mword_t'(NOut));
`endif
    end

    // Leaving COLLECT/DRAIN looks at the post-edge FIFO count so a last-edge pop is honoured.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = COLLECT;
            COLLECT: begin
                if (start)     state_n = COLLECT;
                else if (halt) state_n = (count_n == '0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (start)                 state_n = COLLECT;
                else if (count_n == '0)    state_n = DONE;
            end
            DONE:    if (start) state_n = COLLECT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            out_ready <= 1'b0;
            rx_count  <= '0;
            bad_index <= BadNone;
            error     <= 1'b0;
            finished  <= 1'b0;
            success   <= 1'b0;
        end else begin
            state     <= state_n;
            out_ready <= (state_n == COLLECT) && (count_n != CW'(FifoDepth));
            rx_count  <= rx_n;
            bad_index <= bad_n;
            error     <= error_n;
            finished  <= (state_n == DONE);
            if (state_n != DONE)    success <= 1'b0;
            else if (state != DONE) success <= success_n;
        end
    end

endmodule

// File: tb/tb_out_channel_reader.sv
// Bench for out_channel_reader: vector table, hand-written corner sequences, random streams vs model.
module tb_out_channel_reader;

    localparam int MW   = 12;
    localparam int NOUT = 2;
    localparam int FD   = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          exp_we = 1'b0;
    logic [0:0]    exp_addr = '0;
    logic [MW-1:0] exp_data = '0;
    logic          out_valid = 1'b0;
    logic [MW-1:0] out_data = '0;
    logic          out_ready;
    logic          hold = 1'b0;
    logic          halt = 1'b0;
    logic [MW-1:0] rx_count;
    logic [MW-1:0] bad_index;
    logic          finished;
    logic          success;

    always #5 clock = ~clock;

    out_channel_reader #(
        .MemoryElementWidth (MW),
        .NOut               (NOUT),
        .FifoDepth          (FD)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .exp_we    (exp_we),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .hold      (hold),
        .halt      (halt),
        .rx_count  (rx_count),
        .bad_index (bad_index),
        .finished  (finished),
        .success   (success)
    );

    typedef struct packed {
        logic [MW-1:0]      e0;
        logic [MW-1:0]      e1;
        logic [3:0]         n;
        logic [4:0][MW-1:0] w;
        logic               succ;
        logic [MW-1:0]      rx;
        logic [MW-1:0]      bad;
    } vec_t;

    vec_t          vecs [8];
    int            errors = 0;
    int            checks = 0;
    logic [MW-1:0] etab [NOUT];
    logic [MW-1:0] wq [16];
    int            wn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; exp_we = 1'b0; out_valid = 1'b0;
        hold = 1'b0; halt = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic load_table(input logic [MW-1:0] a, input logic [MW-1:0] b);
        etab[0] = a;
        etab[1] = b;
        exp_we = 1'b1; exp_addr = 1'b0; exp_data = a;
        step();
        exp_addr = 1'b1; exp_data = b;
        step();
        exp_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [MW-1:0] w, input bit rnd, input bit halt_last);
        logic acc;
        acc = 1'b0;
        out_valid = 1'b1;
        out_data  = w;
        for (int c = 0; c < 200 && !acc; c++) begin
            if (rnd) hold = ($urandom_range(0, 2) == 0);
            @(negedge clock);
            acc = out_ready;
            if (acc && halt_last) halt = 1'b1;
            step();
        end
        out_valid = 1'b0;
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic finish_wait(input bit rnd);
        logic found;
        found = 1'b0;
        halt  = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
            found = finished;
            if (!found) step();
        end
        step();
        hold = 1'b0;
        halt = 1'b0;
        check("finished", 32'(found), 32'd1);
    endtask

    task automatic run_stream(input bit rnd);
        pulse_start();
        for (int i = 0; i < wn; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) step();
            send(wq[i], rnd, rnd && (i == wn - 1) && ($urandom_range(0, 1) == 1));
        end
        if (rnd) repeat ($urandom_range(0, 2)) step();
        finish_wait(rnd);
    endtask

    // Reference: per-word rule applied to the whole list at once.
    task automatic model(output logic s, output logic [MW-1:0] rx, output logic [MW-1:0] bad);
        logic err;
        logic ok;
        err = 1'b0;
        bad = '1;
        for (int i = 0; i < wn; i++) begin
`ifdef OUT_CHANNEL_WRAP_EN
            ok = (wq[i] == etab[i % NOUT]);
`else
            ok = (i < NOUT) ? (wq[i] == etab[i]) : 1'b0;
`endif
            if (!ok) begin
                if (!err) bad = MW'(i);
                err = 1'b1;
            end
        end
        rx = MW'(wn);
`ifdef OUT_CHANNEL_WRAP_EN
        s = !err && (wn >= NOUT);
`else
        s = !err && (wn == NOUT);
`endif
    endtask

    task automatic check_result(input logic s, input logic [MW-1:0] rx, input logic [MW-1:0] bad);
        check("success", 32'(success), 32'(s));
        check("rx_count", 32'(rx_count), 32'(rx));
        check("bad_index", 32'(bad_index), 32'(bad));
    endtask

    task automatic set_vec(input int k, input logic [MW-1:0] e0, input logic [MW-1:0] e1,
                           input int n, input logic [MW-1:0] w0, input logic [MW-1:0] w1,
                           input logic [MW-1:0] w2, input logic s, input logic [MW-1:0] rx,
                           input logic [MW-1:0] bad);
        vecs[k].e0 = e0; vecs[k].e1 = e1; vecs[k].n = 4'(n);
        vecs[k].w = '0;
        vecs[k].w[0] = w0; vecs[k].w[1] = w1; vecs[k].w[2] = w2;
        vecs[k].succ = s; vecs[k].rx = rx; vecs[k].bad = bad;
    endtask

    initial begin
        logic          ms;
        logic [MW-1:0] mrx;
        logic [MW-1:0] mbad;

        set_vec(0, 3, 5, 2, 3, 5, 0, 1'b1, 2, 12'hFFF);
        set_vec(1, 3, 5, 2, 3, 4, 0, 1'b0, 2, 12'd1);
        set_vec(2, 3, 5, 1, 3, 0, 0, 1'b0, 1, 12'hFFF);
        set_vec(3, 3, 5, 3, 3, 5, 7, 1'b0, 3, 12'd2);
`ifdef OUT_CHANNEL_WRAP_EN
        set_vec(4, 3, 5, 3, 3, 5, 3, 1'b1, 3, 12'hFFF);
`else
        set_vec(4, 3, 5, 3, 3, 5, 3, 1'b0, 3, 12'd2);
`endif
        set_vec(5, 3, 5, 0, 0, 0, 0, 1'b0, 0, 12'hFFF);
        set_vec(6, 12'hFFF, 12'h000, 2, 12'hFFF, 12'h000, 0, 1'b1, 2, 12'hFFF);
        set_vec(7, 3, 5, 2, 4, 5, 0, 1'b0, 2, 12'd0);

        // Reset state
        do_reset();
        check("rst_ready", 32'(out_ready), 32'd0);
        check("rst_rx", 32'(rx_count), 32'd0);
        check("rst_bad", 32'(bad_index), 32'hFFF);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_success", 32'(success), 32'd0);

        // Table-driven scenarios
        for (int k = 0; k < 8; k++) begin
            do_reset();
            load_table(vecs[k].e0, vecs[k].e1);
            wn = int'(vecs[k].n);
            for (int j = 0; j < wn; j++) wq[j] = vecs[k].w[j];
            run_stream(1'b0);
            check_result(vecs[k].succ, vecs[k].rx, vecs[k].bad);
        end

        // Compare latency: no bypass of an empty FIFO
        do_reset();
        load_table(3, 5);
        pulse_start();
        check("ready_collect", 32'(out_ready), 32'd1);
        out_valid = 1'b1; out_data = 3;
        step();
        out_valid = 1'b0;
        check("no_bypass", 32'(rx_count), 32'd0);
        step();
        check("cmp_latency", 32'(rx_count), 32'd1);
        send(5, 1'b0, 1'b0);
        finish_wait(1'b0);
        check_result(1'b1, 2, 12'hFFF);

        // Back-pressure with the comparator held
        do_reset();
        load_table(3, 5);
        hold = 1'b1;
        pulse_start();
        wn = 5;
        wq[0] = 3; wq[1] = 5; wq[2] = 3; wq[3] = 5; wq[4] = 3;
        for (int i = 0; i < 4; i++) send(wq[i], 1'b0, 1'b0);
        out_valid = 1'b1; out_data = wq[4];
        repeat (3) step();
        @(negedge clock);
        check("ready_full", 32'(out_ready), 32'd0);
        check("hold_no_cmp", 32'(rx_count), 32'd0);
        step();
        hold = 1'b0;
        send(wq[4], 1'b0, 1'b0);
        finish_wait(1'b0);
        model(ms, mrx, mbad);
        check_result(ms, mrx, mbad);

        // Reset mid-stream, table survives, writes outside IDLE ignored
        do_reset();
        load_table(3, 5);
        hold = 1'b1;
        pulse_start();
        send(3, 1'b0, 1'b0);
        send(5, 1'b0, 1'b0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        hold = 1'b0;
        check("mid_rst_ready", 32'(out_ready), 32'd0);
        check("mid_rst_rx", 32'(rx_count), 32'd0);
        check("mid_rst_bad", 32'(bad_index), 32'hFFF);
        check("mid_rst_finished", 32'(finished), 32'd0);
        check("mid_rst_success", 32'(success), 32'd0);
        step();
        check("mid_rst_idle_rx", 32'(rx_count), 32'd0);
        pulse_start();
        exp_we = 1'b1; exp_addr = 1'b0; exp_data = 9;
        step();
        exp_we = 1'b0;
        send(3, 1'b0, 1'b0);
        send(5, 1'b0, 1'b0);
        finish_wait(1'b0);
        check_result(1'b1, 2, 12'hFFF);

        // Randomized streams against the model
        for (int t = 0; t < 40; t++) begin
            do_reset();
            load_table(MW'($urandom_range(0, 3)), MW'($urandom_range(0, 3)));
            wn = $urandom_range(0, 7);
            for (int j = 0; j < wn; j++)
                wq[j] = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 3)) : etab[j % NOUT];
            run_stream(1'b1);
            model(ms, mrx, mbad);
            check_result(ms, mrx, mbad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
